// File: rtl/icache_pkg.sv
// Shared state encoding and address-split helpers for the fetch-side instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_LINES  = 16;

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int line_words, input int num_lines);
        return 32 - idx_w(num_lines) - off_w(line_words);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache: async read, sync word and tag writes,
// per-line valid clear, and clear-all of the valid bits on reset.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int TAG_W      = tag_w(DEF_LINE_WORDS, DEF_NUM_LINES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(NUM_LINES)-1:0]  rd_idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
    output logic                          rd_valid_o,
    output logic [TAG_W-1:0]              rd_tag_o,
    output logic [31:0]                   rd_data_o,
    input  logic                          word_we_i,
    input  logic [$clog2(NUM_LINES)-1:0]  wr_idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word_i,
    input  logic [31:0]                   wr_data_i,
    input  logic                          tag_we_i,
    input  logic [TAG_W-1:0]              wr_tag_i,
    input  logic                          clr_i,
    input  logic [$clog2(NUM_LINES)-1:0]  clr_idx_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q[clr_idx_i] <= 1'b0;
        end else if (tag_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (word_we_i) begin
            data_q[wr_idx_i][wr_word_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped instruction cache responder for the fetch PC: combinational hit path,
// and a line refill FSM talking to instruction memory over a req/ack handshake.
module icache_fetch_ctrl
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        hit,
    output logic [31:0] instr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(NUM_LINES);
    localparam int TAG_W  = tag_w(LINE_WORDS, NUM_LINES);
    localparam int WORD_W = OFF_W - 2;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    logic [WORD_W-1:0] pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic              unused_pc_bits;

    assign pc_word        = pc[OFF_W-1:2];
    assign pc_idx         = pc[OFF_W+IDX_W-1:OFF_W];
    assign pc_tag         = pc[31:OFF_W+IDX_W];
    assign unused_pc_bits = ^pc[1:0];

    state_e            state_q, state_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;

    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [31:0]       line_data;
    logic              word_we, tag_we, clr_en;

    icache_line_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (pc_idx),
        .rd_word_i  (pc_word),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .word_we_i  (word_we && !rst),
        .wr_idx_i   (miss_idx_q),
        .wr_word_i  (cnt_q),
        .wr_data_i  (mem_rdata),
        .tag_we_i   (tag_we && !rst),
        .wr_tag_i   (miss_tag_q),
        .clr_i      (clr_en && !rst),
        .clr_idx_i  (pc_idx)
    );

    // Purely combinational from registered state and pc so it settles well before negedge.
    assign hit      = (state_q == IDLE) && line_valid && (line_tag == pc_tag);
    assign instr    = hit ? line_data : 32'h0;
    assign mem_req  = (state_q == FILL);
    assign mem_addr = mem_req ? {miss_tag_q, miss_idx_q, cnt_q, 2'b00} : 32'h0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        word_we    = 1'b0;
        tag_we     = 1'b0;
        clr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d    = FILL;
                    miss_tag_d = pc_tag;
                    miss_idx_d = pc_idx;
                    cnt_d      = '0;
                    clr_en     = 1'b1;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    word_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                tag_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        miss_tag_q <= miss_tag_d;
        miss_idx_q <= miss_idx_d;
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Bench for icache_fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level cache model, with a memory responder of programmable ack delay.
module tb_icache_fetch_ctrl;

    localparam int LW = 4;
    localparam int NL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    icache_fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .hit       (hit),
        .instr     (instr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which lines hold which tag, and the progress of an in-flight refill.
    bit          m_known = 1'b0;
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    bit          m_busy   = 1'b0;
    bit          m_commit = 1'b0;
    logic [31:0] m_base   = 32'h0;
    int          m_k      = 0;

    // Responder controls and sampled outputs.
    int          delay_g   = 0;
    int          wcnt      = 0;
    bit          force_ack = 1'b0;
    bit          stray_g   = 1'b0;
    logic        s_hit, s_req;
    logic [31:0] s_instr, s_addr;
    logic [31:0] acked_q [$];

    function automatic int line_of(input logic [31:0] a);
        return int'((a / (LW * 4)) % NL);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (LW * 4 * NL);
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return !m_busy && m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            m_busy   = 1'b0;
            m_commit = 1'b0;
            m_known  = 1'b1;
        end else if (!m_known) begin
            m_known = 1'b0;
        end else if (!m_busy) begin
            if (!model_hit(pc)) begin
                m_busy   = 1'b1;
                m_commit = 1'b0;
                m_base   = pc & ~32'(LW * 4 - 1);
                m_k      = 0;
                m_valid[line_of(pc)] = 1'b0;
            end
        end else if (m_commit) begin
            m_valid[line_of(m_base)] = 1'b1;
            m_tag[line_of(m_base)]   = tag_of(m_base);
            m_busy = 1'b0;
        end else if (mem_ack) begin
            if (m_k == LW - 1) m_commit = 1'b1;
            else m_k++;
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step();
        logic        e_hit, e_req;
        logic [31:0] e_instr, e_addr;
        if (mem_req === 1'b1 && !rst) mem_ack = (wcnt >= delay_g);
        else mem_ack = force_ack | (stray_g & ($urandom_range(0, 7) == 0));
        mem_rdata = mem_ack ? (mem_addr ^ 32'hA5A5_0000) : $urandom;
        #1;
        s_hit = hit; s_instr = instr; s_req = mem_req; s_addr = mem_addr;
        if (m_known) begin
            e_hit   = model_hit(pc);
            e_instr = e_hit ? ((pc & ~32'h3) ^ 32'hA5A5_0000) : 32'h0;
            e_req   = m_busy && !m_commit;
            e_addr  = e_req ? (m_base + 32'(4 * m_k)) : 32'h0;
            chk("hit", 32'(s_hit), 32'(e_hit));
            chk("instr", s_instr, e_instr);
            chk("mem_req", 32'(s_req), 32'(e_req));
            chk("mem_addr", s_addr, e_addr);
        end
        if (mem_req === 1'b1 && mem_ack && !rst) acked_q.push_back(mem_addr);
        model_update();
        if (mem_req === 1'b1 && !mem_ack && !rst) wcnt++;
        else wcnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_hit(input int budget, output int n);
        n = 0;
        step();
        while (!s_hit && n < budget) begin
            n++;
            step();
        end
        if (s_hit !== 1'b1) chk("hit_timeout", 32'(s_hit), 32'd1);
    endtask

    task automatic chk_acked(input string name, input logic [31:0] exp_q [$]);
        chk({name, "_count"}, 32'(acked_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk(name, (i < acked_q.size()) ? acked_q[i] : 32'hDEAD_DEAD, exp_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] exp_q [$];

        rst = 1'b1; pc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("reset_hit", 32'(s_hit), 32'd0);
        chk("reset_instr", s_instr, 32'h0);
        chk("reset_req", 32'(s_req), 32'd0);
        chk("reset_addr", s_addr, 32'h0);
        rst = 1'b0;

        // Cold miss on 0x100 with zero-wait memory.
        acked_q.delete();
        pc = 32'h100;
        run_until_hit(40, n);
        chk("c1_latency", 32'(n), 32'd6);
        chk("c1_instr", s_instr, 32'hA5A5_0100);
        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        chk_acked("c1_addr", exp_q);

        // Same line, other word: hits immediately.
        pc = 32'h108;
        step();
        chk("c2_hit", 32'(s_hit), 32'd1);
        chk("c2_instr", s_instr, 32'hA5A5_0108);
        chk("c2_req", 32'(s_req), 32'd0);

        // Conflicting tag on the same index evicts 0x100.
        acked_q.delete();
        pc = 32'h500;
        run_until_hit(40, n);
        chk("c3_latency", 32'(n), 32'd6);
        chk("c3_instr", s_instr, 32'hA5A5_0500);
        exp_q = '{32'h500, 32'h504, 32'h508, 32'h50C};
        chk_acked("c3_addr", exp_q);
        pc = 32'h100;
        step();
        chk("c3_remiss", 32'(s_hit), 32'd0);
        run_until_hit(40, n);

        // Three cycles per word.
        delay_g = 2;
        pc = 32'h240;
        run_until_hit(80, n);
        chk("c4_latency", 32'(n), 32'd14);
        chk("c4_instr", s_instr, 32'hA5A5_0240);
        delay_g = 0;

        // Reset after the second ack aborts the fill; a stray ack then does nothing.
        acked_q.delete();
        pc = 32'h300;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        chk("c5_req_after_rst", 32'(s_req), 32'd0);
        chk("c5_hit_after_rst", 32'(s_hit), 32'd0);
        step();
        chk("c5_refill_req", 32'(s_req), 32'd1);
        chk("c5_refill_addr", s_addr, 32'h300);
        run_until_hit(40, n);
        chk("c5_instr", s_instr, 32'hA5A5_0300);

        // pc moves mid-fill: the latched line finishes first.
        acked_q.delete();
        pc = 32'h100;
        step();
        step();
        step();
        pc = 32'h200;
        run_until_hit(60, n);
        chk("c6_latency", 32'(n), 32'd9);
        chk("c6_instr", s_instr, 32'hA5A5_0200);
        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204, 32'h208, 32'h20C};
        chk_acked("c6_addr", exp_q);

        // Randomized traffic with conflicts, ack delays, stray acks and occasional reset.
        stray_g = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0)
                pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
                   | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if (mem_req !== 1'b1) delay_g = $urandom_range(0, 2);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
